// File: rtl/post_proc_pack_pkg.sv
// Shared types and constants for the post-processing pack stage.
// Included by the requantiser sub-module and the top level.
package swin_pp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} pp_state_e;

  localparam int INT8_MAX   = 127;
  localparam int INT8_MIN   = -128;
  localparam int LANES      = 4;
  localparam int PIPE_DEPTH = 3;

endpackage

// File: rtl/post_proc_pack_if.sv
// Bundle of config, accumulator-input and output-memory write signals for post_proc_pack.
// The block sits on the slave side; the sequencer/PE array/memory side uses master.
interface post_proc_pack_if #(
  parameter int OAW = 19,
  parameter int SCW = 16,
  parameter int SHW = 5
);
  logic                  cfg_start;
  logic [OAW-1:0]        cfg_base_addr;
  logic [OAW-1:0]        cfg_len;
  logic signed [SCW-1:0] cfg_scale;
  logic [SHW-1:0]        cfg_shift;
  logic                  cfg_relu;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_data;
  logic [31:0]           pp_data;
  logic [OAW-1:0]        pp_wr_addr;
  logic                  pp_wr_en;
  logic                  busy;
  logic                  done;

  modport master (
    output cfg_start, cfg_base_addr, cfg_len, cfg_scale, cfg_shift, cfg_relu,
    output in_valid, in_data,
    input  in_ready, pp_data, pp_wr_addr, pp_wr_en, busy, done
  );

  modport slave (
    input  cfg_start, cfg_base_addr, cfg_len, cfg_scale, cfg_shift, cfg_relu,
    input  in_valid, in_data,
    output in_ready, pp_data, pp_wr_addr, pp_wr_en, busy, done
  );
endinterface

// File: rtl/post_proc_pack_requant.sv
// Two-stage requantiser: full-width multiply, then rounding shift, optional ReLU
// and int8 saturation. valid_o follows valid_i by exactly two cycles.
module pp_requant
  import swin_pp_pkg::*;
#(
  parameter int SCW = 16,
  parameter int SHW = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic signed [31:0]    data_i,
  input  logic signed [SCW-1:0] scale_i,
  input  logic [SHW-1:0]        shift_i,
  input  logic                  relu_i,
  output logic                  valid_o,
  output logic [7:0]            res_o
);

  logic signed [47:0] prod_q;
  logic               v1_q;
  logic               v2_q;
  logic [7:0]         res_q;
  logic signed [48:0] sum;
  logic signed [48:0] rnd;
  logic signed [48:0] clip;
  logic [7:0]         res_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      prod_q <= '0;
    end else begin
      v1_q <= valid_i;
      if (valid_i) prod_q <= 48'(data_i) * 48'(scale_i);
    end
  end

  // One guard bit above the product keeps the rounding add from overflowing.
  always_comb begin
    sum = {prod_q[47], prod_q};
    if (shift_i != '0) sum = sum + (49'sd1 <<< (shift_i - 5'd1));
    rnd  = sum >>> shift_i;
    clip = (relu_i && rnd[48]) ? '0 : rnd;
    if (clip > 49'(INT8_MAX))      res_d = 8'(INT8_MAX);
    else if (clip < 49'(INT8_MIN)) res_d = 8'(INT8_MIN);
    else                           res_d = clip[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      res_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) res_q <= res_d;
    end
  end

  assign valid_o = v2_q;
  assign res_o   = res_q;

endmodule

// File: rtl/post_proc_pack.sv
// Job FSM, element/word counters, int8 lane packer and output-memory address
// generation wrapped around the two-stage requantiser.
module post_proc_pack
  import swin_pp_pkg::*;
#(
  parameter int OAW = 19,
  parameter int SCW = 16,
  parameter int SHW = 5
) (
  input  logic clk,
  input  logic rst_n,
  post_proc_pack_if.slave bus
);

  localparam int LW = $clog2(LANES);

  pp_state_e             state_q, state_d;
  logic [OAW-1:0]        base_q, len_q, word_cnt_q, pp_addr_q;
  logic signed [SCW-1:0] scale_q;
  logic [SHW-1:0]        shift_q;
  logic                  relu_q;
  logic [OAW+1:0]        elem_cnt_q;
  logic [LW-1:0]         lane_q;
  logic [23:0]           pack_q;
  logic [31:0]           pp_data_q;
  logic                  pp_en_q;
  logic                  start_job, accept, last_elem, busy, done, in_ready;
  logic                  rq_valid;
  logic [7:0]            rq_res;

  assign accept    = bus.in_valid && (state_q == RUN);
  assign last_elem = (elem_cnt_q == ({len_q, 2'b00} - {{(OAW+1){1'b0}}, 1'b1}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // DRAIN ends on the cycle the final word is on the write port, so done follows it.
  always_comb begin
    state_d   = state_q;
    start_job = 1'b0;
    busy      = 1'b0;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_start) begin
          start_job = 1'b1;
          state_d   = (bus.cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (accept && last_elem) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pp_en_q && (word_cnt_q == len_q)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      len_q      <= '0;
      scale_q    <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      elem_cnt_q <= '0;
      word_cnt_q <= '0;
      lane_q     <= '0;
      pack_q     <= '0;
      pp_data_q  <= '0;
      pp_addr_q  <= '0;
      pp_en_q    <= 1'b0;
    end else begin
      pp_en_q <= 1'b0;
      if (start_job) begin
        base_q     <= bus.cfg_base_addr;
        len_q      <= bus.cfg_len;
        scale_q    <= bus.cfg_scale;
        shift_q    <= bus.cfg_shift;
        relu_q     <= bus.cfg_relu;
        elem_cnt_q <= '0;
        word_cnt_q <= '0;
        lane_q     <= '0;
        pack_q     <= '0;
      end
      if (accept) elem_cnt_q <= elem_cnt_q + 1'b1;
      if (rq_valid) begin
        if (lane_q == LW'(LANES - 1)) begin
          pp_data_q  <= {rq_res, pack_q};
          pp_addr_q  <= base_q + word_cnt_q;
          pp_en_q    <= 1'b1;
          word_cnt_q <= word_cnt_q + 1'b1;
        end else begin
          pack_q[{lane_q, 3'b000} +: 8] <= rq_res;
        end
        lane_q <= lane_q + 1'b1;
      end
    end
  end

  pp_requant #(.SCW(SCW), .SHW(SHW)) u_requant (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (accept),
    .data_i  (bus.in_data),
    .scale_i (scale_q),
    .shift_i (shift_q),
    .relu_i  (relu_q),
    .valid_o (rq_valid),
    .res_o   (rq_res)
  );

  assign bus.in_ready   = in_ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pp_data    = pp_data_q;
  assign bus.pp_wr_addr = pp_addr_q;
  assign bus.pp_wr_en   = pp_en_q;

endmodule
